regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_if.sv | 24 ++
 rtl/regfile_wb_arbiter_wb_fifo.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 50 +++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, constants and types for the write-back arbiter.
package regfile_wb_arbiter_pkg;
    localparam int RegAddrW  = 5;
    localparam int RegW      = 32;
    localparam int WbLqDepth = 2;
    localparam int LqPtrW    = $clog2(WbLqDepth);
    localparam int LqCntW    = $clog2(WbLqDepth + 1);
    typedef logic [RegW-1:0] reg_bus_t;
    typedef logic [RegAddrW-1:0] reg_addr_t;
    localparam reg_bus_t ZeroWord = '0;
    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;
    typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_LQ} grant_e;
    typedef struct packed {
        reg_addr_t addr;
        reg_bus_t  data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: ALU/load write-back requests and the register-file write port.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;
    logic      alu_valid;
    logic      alu_ready;
    reg_addr_t alu_addr;
    reg_bus_t  alu_data;
    logic      mem_valid;
    logic      mem_ready;
    reg_addr_t mem_addr;
    reg_bus_t  mem_data;
    logic      w_enable;
    reg_addr_t w_addr;
    reg_bus_t  w_data;
    logic      wb_pending;
    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready, w_enable, w_addr, w_data, wb_pending
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready, w_enable, w_addr, w_data, wb_pending
    );
endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// regfile_wb_arbiter_wb_fifo: in-order load queue with per-entry destination compare.
module regfile_wb_arbiter_wb_fifo
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  wb_req_t              din,
    input  reg_addr_t            cmp_addr,
    output wb_req_t              head,
    output logic [LqCntW-1:0]    count,
    output logic [WbLqDepth-1:0] match
);
    wb_req_t mem [WbLqDepth];
    logic [LqPtrW-1:0] rd_ptr, wr_ptr, off;
    always_comb begin
        head = mem[rd_ptr];
        off = '0;
        match = '0;
        for (int k = 0; k < WbLqDepth; k++) begin
            // an entry is live when its distance from the head is below the count
            off = LqPtrW'(k) - rd_ptr;
            match[k] = (LqCntW'(off) < count) && (mem[k].addr == cmp_addr);
        end
    end
    always_ff @(posedge clk)
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            count <= count + LqCntW'(push) - LqCntW'(pop);
        end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and load write-backs onto one register-file write port.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input logic clk,
    input logic rst,
    regfile_wb_arbiter_if.slave bus
);
    logic [LqCntW-1:0]    count;
    logic [WbLqDepth-1:0] match;
    wb_req_t head, win;
    logic full, push, pop, conflict, wr;
    grant_e grant;
    always_comb begin
        full = count == LqCntW'(WbLqDepth);
        bus.mem_ready = !rst && !full;
        push = bus.mem_valid && bus.mem_ready;
        // hold an ALU write behind any queued or incoming load to the same register
        conflict = (bus.alu_addr != '0) && (|match || (push && bus.mem_addr == bus.alu_addr));
        bus.alu_ready = !rst && !full && !conflict;
        grant = full ? GNT_LQ :
                (bus.alu_valid && bus.alu_ready) ? GNT_ALU :
                (count != '0) ? GNT_LQ : GNT_NONE;
        pop = grant == GNT_LQ;
        win = (grant == GNT_ALU) ? wb_req_t'({bus.alu_addr, bus.alu_data}) : head;
        wr = (grant != GNT_NONE) && (win.addr != '0);
        bus.wb_pending = count != '0;
    end
    regfile_wb_arbiter_wb_fifo wb_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .din      (wb_req_t'({bus.mem_addr, bus.mem_data})),
        .cmp_addr (bus.alu_addr),
        .head     (head),
        .count    (count),
        .match    (match)
    );
    always_ff @(posedge clk)
        if (rst) begin
            bus.w_enable <= Disable;
            bus.w_addr <= '0;
            bus.w_data <= ZeroWord;
        end else begin
            bus.w_enable <= wr;
            bus.w_addr <= wr ? win.addr : '0;
            bus.w_data <= wr ? win.data : ZeroWord;
        end
endmodule
